// File: rtl/clbp_trig_arbiter.sv
// clbp_trig_arbiter
//   Shares one sin/cos (CORDIC) unit among NUM_REQ CLBP engines. A round-robin
//   arbiter picks one requester, issues its angle to the trig unit, collects
//   cos and sin in either order, snaps +/-(ONE-1) to +/-ONE and returns the
//   result to the winner. One transaction is in flight at a time. A transaction
//   whose results do not arrive within TIMEOUT wait cycles is aborted with
//   rsp_err set and zero data.
//
// Optional feature: define CLBP_TRIG_CACHE_EN to add a one-entry result cache.
//   A request whose angle matches the last good result is answered directly,
//   without touching the trig unit.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_req_valid[NUM_REQ]    request level per engine, held until its rsp
//   i_req_theta[NUM_REQ*W]  per-engine angle, slice i = [i*W +: W]
//   o_rsp_valid[NUM_REQ]    one-hot, one-cycle response pulse
//   o_rsp_cos/o_rsp_sin     snapped results, broadcast, qualified by rsp_valid
//   o_rsp_err               timeout flag, qualified by rsp_valid
//   o_theta/o_theta_valid   issue to trig unit (one-cycle strobe)
//   i_cos_data/i_cos_valid  trig cos return
//   i_sin_data/i_sin_valid  trig sin return
//   o_busy                  high whenever not IDLE
module clbp_trig_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int INT_WIDTH  = 9,
  parameter  int FRAC_WIDTH = 16,
  parameter  int TIMEOUT    = 15,
  localparam int W          = INT_WIDTH + FRAC_WIDTH,
  localparam int PW         = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*W-1:0] i_req_theta,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [W-1:0]         o_rsp_cos,
  output logic [W-1:0]         o_rsp_sin,
  output logic                 o_rsp_err,
  output logic [W-1:0]         o_theta,
  output logic                 o_theta_valid,
  input  logic [W-1:0]         i_cos_data,
  input  logic                 i_cos_valid,
  input  logic [W-1:0]         i_sin_data,
  input  logic                 i_sin_valid,
  output logic                 o_busy
);

  localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1} << FRAC_WIDTH;
  localparam logic [W-1:0]  ONE_M1  = ONE - 1'b1;
  localparam logic [W-1:0]  NEG_ONE = ~ONE + 1'b1;
  localparam logic [W-1:0]  NEG_M1  = ~ONE_M1 + 1'b1;
  localparam logic [PW:0]   NR      = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);
  localparam logic [7:0]    TO      = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  function automatic logic [W-1:0] snap(input logic [W-1:0] d);
    if (d == ONE_M1)      snap = ONE;
    else if (d == NEG_M1) snap = NEG_ONE;
    else                  snap = d;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] g);
    onehot    = '0;
    onehot[g] = 1'b1;
  endfunction

  state_t                   r_state;
  logic [PW-1:0]            r_rr_ptr, r_grant;
  logic [W-1:0]             r_theta, r_cos, r_sin, r_rsp_cos, r_rsp_sin;
  logic                     r_theta_valid, r_rsp_err, r_cos_f, r_sin_f;
  logic [NUM_REQ-1:0]       r_rsp_valid;
  logic [7:0]               r_cnt;

  logic [NUM_REQ-1:0][W-1:0] w_theta_arr;
  logic [PW-1:0]             w_grant;
  logic                      w_any, w_hit;
  logic [PW:0]               w_idx;
  logic                      w_cos_got, w_sin_got;
  logic [W-1:0]              w_cos_val, w_sin_val, w_c_cos, w_c_sin;
  logic [7:0]                w_cnt_nxt;

  assign w_theta_arr = i_req_theta;

  // Round-robin: first requester at or after r_rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_any && i_req_valid[w_idx[PW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_idx[PW-1:0];
      end
    end
  end

  // This cycle's strobes count toward completion so a result arriving on the
  // last needed cycle is not delayed by one clock.
  assign w_cos_got = r_cos_f | i_cos_valid;
  assign w_sin_got = r_sin_f | i_sin_valid;
  assign w_cos_val = i_cos_valid ? i_cos_data : r_cos;
  assign w_sin_val = i_sin_valid ? i_sin_data : r_sin;
  assign w_cnt_nxt = r_cnt + 8'd1;

`ifdef CLBP_TRIG_CACHE_EN
  logic         r_c_valid;
  logic [W-1:0] r_c_theta, r_c_cos, r_c_sin;

  assign w_hit   = r_c_valid && (r_c_theta == w_theta_arr[w_grant]);
  assign w_c_cos = r_c_cos;
  assign w_c_sin = r_c_sin;

  // Only good completions are cached; r_theta still holds the issued angle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c_valid <= 1'b0;
      r_c_theta <= '0;
      r_c_cos   <= '0;
      r_c_sin   <= '0;
    end else if (r_state == S_WAIT && w_cos_got && w_sin_got) begin
      r_c_valid <= 1'b1;
      r_c_theta <= r_theta;
      r_c_cos   <= snap(w_cos_val);
      r_c_sin   <= snap(w_sin_val);
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_c_cos = '0;
  assign w_c_sin = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_theta       <= '0;
      r_theta_valid <= 1'b0;
      r_rsp_valid   <= '0;
      r_rsp_cos     <= '0;
      r_rsp_sin     <= '0;
      r_rsp_err     <= 1'b0;
      r_cos         <= '0;
      r_sin         <= '0;
      r_cos_f       <= 1'b0;
      r_sin_f       <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid   <= '0;
          r_rsp_err     <= 1'b0;
          r_theta_valid <= 1'b0;
          if (w_any) begin
            r_grant <= w_grant;
            if (w_hit) begin
              r_rsp_valid <= onehot(w_grant);
              r_rsp_cos   <= w_c_cos;
              r_rsp_sin   <= w_c_sin;
              r_state     <= S_RESP;
            end else begin
              r_theta       <= w_theta_arr[w_grant];
              r_theta_valid <= 1'b1;
              r_cos_f       <= 1'b0;
              r_sin_f       <= 1'b0;
              r_cnt         <= '0;
              r_state       <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_theta_valid <= 1'b0;
          r_cnt         <= w_cnt_nxt;
          if (i_cos_valid) begin
            r_cos   <= i_cos_data;
            r_cos_f <= 1'b1;
          end
          if (i_sin_valid) begin
            r_sin   <= i_sin_data;
            r_sin_f <= 1'b1;
          end
          if (w_cos_got && w_sin_got) begin
            r_rsp_valid <= onehot(r_grant);
            r_rsp_err   <= 1'b0;
            r_rsp_cos   <= snap(w_cos_val);
            r_rsp_sin   <= snap(w_sin_val);
            r_state     <= S_RESP;
          end else if (w_cnt_nxt == TO) begin
            r_rsp_valid <= onehot(r_grant);
            r_rsp_err   <= 1'b1;
            r_rsp_cos   <= '0;
            r_rsp_sin   <= '0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_rr_ptr    <= (r_grant == LAST) ? '0 : r_grant + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_cos     = r_rsp_cos;
  assign o_rsp_sin     = r_rsp_sin;
  assign o_rsp_err     = r_rsp_err;
  assign o_theta       = r_theta;
  assign o_theta_valid = r_theta_valid;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_clbp_trig_arbiter.sv
// Directed bench for clbp_trig_arbiter: a small trig-unit model answers each
// theta_valid after per-channel latencies; the main sequence drives requests
// and compares outputs against hand-computed values.
module tb_clbp_trig_arbiter;
  localparam int NR = 2;
  localparam int W  = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_theta;
  logic [NR-1:0]     rsp_valid;
  logic [W-1:0]      rsp_cos, rsp_sin, theta, cos_d, sin_d;
  logic              rsp_err, theta_valid, cos_valid, sin_valid, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clbp_trig_arbiter #(.NUM_REQ(NR), .INT_WIDTH(9), .FRAC_WIDTH(16), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_theta(req_theta),
    .o_rsp_valid(rsp_valid), .o_rsp_cos(rsp_cos), .o_rsp_sin(rsp_sin), .o_rsp_err(rsp_err),
    .o_theta(theta), .o_theta_valid(theta_valid),
    .i_cos_data(cos_d), .i_cos_valid(cos_valid),
    .i_sin_data(sin_d), .i_sin_valid(sin_valid),
    .o_busy(busy)
  );

  // Trig model: strobes cos lc cycles and sin ls cycles after theta_valid.
  // Driven on the falling edge so it never races the main sequence.
  int lc = 1, ls = 1, ccnt = 0, scnt = 0;
  bit men = 1'b1;
  int late_req = 0, late_done = 0;

  initial begin
    cos_valid = 1'b0;
    sin_valid = 1'b0;
    forever begin
      @(negedge clk);
      cos_valid = 1'b0;
      sin_valid = 1'b0;
      if (ccnt > 0) begin ccnt--; if (ccnt == 0) cos_valid = 1'b1; end
      if (scnt > 0) begin scnt--; if (scnt == 0) sin_valid = 1'b1; end
      if (theta_valid && men) begin ccnt = lc; scnt = ls; end
      if (late_req != late_done) begin
        late_done = late_req;
        cos_valid = 1'b1;
        sin_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tv(input string tag);
    int n = 0;
    while (!theta_valid && n < 60) begin tick(); n++; end
    chk(tag, 64'(theta_valid), 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid == '0 && n < 60) begin tick(); n++; end
    chk(tag, 64'(rsp_valid != '0), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction for requester idx, checked against expected data.
  task automatic txn(input string tag, input int idx, input logic [W-1:0] th,
                     input logic [W-1:0] c, input logic [W-1:0] s,
                     input logic [W-1:0] ec, input logic [W-1:0] es);
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_theta[idx*W +: W] = th;
    cos_d = c;
    sin_d = s;
    req_valid = oh;
    wait_rsp({tag, "_wait"});
    chk({tag, "_rv"},  64'(rsp_valid), 64'(oh));
    chk({tag, "_cos"}, 64'(rsp_cos),   64'(ec));
    chk({tag, "_sin"}, 64'(rsp_sin),   64'(es));
    chk({tag, "_err"}, 64'(rsp_err),   64'd0);
    req_valid = '0;
    tick();
  endtask

  initial begin
    logic [W-1:0] m65535, m65536;
    int pulses, first;
    logic [W-1:0] pc;
    m65535 = 25'h1FF0001;
    m65536 = 25'h1FF0000;

    rst = 1'b1;
    req_valid = '0;
    req_theta = '0;
    cos_d = '0;
    sin_d = '0;
    tick(); tick(); tick();
    chk("rst_rv",   64'(rsp_valid),   64'd0);
    chk("rst_cos",  64'(rsp_cos),     64'd0);
    chk("rst_sin",  64'(rsp_sin),     64'd0);
    chk("rst_err",  64'(rsp_err),     64'd0);
    chk("rst_th",   64'(theta),       64'd0);
    chk("rst_tv",   64'(theta_valid), 64'd0);
    chk("rst_busy", 64'(busy),        64'd0);
    rst = 1'b0;

    // 1: basic latency, L=3 -> rsp at t+5
    lc = 3; ls = 3;
    cos_d = 46341; sin_d = 46341;
    req_theta[0 +: W] = 51471;
    req_valid = 2'b01;
    tick();
    chk("t1_tv",   64'(theta_valid), 64'd1);
    chk("t1_th",   64'(theta),       64'd51471);
    chk("t1_busy", 64'(busy),        64'd1);
    tick();
    chk("t1_tv_drop", 64'(theta_valid), 64'd0);
    tick(); tick();
    chk("t1_rv_t4", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_rv_t5", 64'(rsp_valid), 64'b01);
    chk("t1_cos",   64'(rsp_cos),   64'd46341);
    chk("t1_sin",   64'(rsp_sin),   64'd46341);
    chk("t1_err",   64'(rsp_err),   64'd0);
    req_valid = '0;
    tick();
    chk("t1_rv_drop", 64'(rsp_valid), 64'd0);
    chk("t1_idle",    64'(busy),      64'd0);

    // 2: two requesters from reset, order 0,1,0,1
    do_reset();
    lc = 2; ls = 2;
    cos_d = 10; sin_d = 20;
    req_theta[0 +: W] = 1000;
    req_theta[W +: W] = 2000;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_tv("t2_tv");
      chk("t2_th", 64'(theta), (i % 2 == 1) ? 64'd2000 : 64'd1000);
      wait_rsp("t2_wait");
      chk("t2_rv", 64'(rsp_valid), (i % 2 == 1) ? 64'b10 : 64'b01);
    end
    req_valid = '0;
    tick(); tick();

    // 3: snapping at +/-(ONE-1)
    lc = 1; ls = 1;
    txn("t3a", 0, 0,   65535,  1,      65536,  1);
    txn("t3b", 0, 0,   m65535, 65534,  m65536, 65534);
    txn("t3c", 1, 77,  100,    m65535, 100,    m65536);

    // 4: no response -> timeout on WAIT cycle 15, late strobes ignored
    men = 1'b0;
    req_theta[0 +: W] = 5;
    req_valid = 2'b01;
    tick();
    chk("t4_tv", 64'(theta_valid), 64'd1);
    repeat (14) tick();
    chk("t4_rv_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("t4_rv",  64'(rsp_valid), 64'b01);
    chk("t4_err", 64'(rsp_err),   64'd1);
    chk("t4_cos", 64'(rsp_cos),   64'd0);
    chk("t4_sin", 64'(rsp_sin),   64'd0);
    req_valid = '0;
    late_req++;
    tick();
    chk("t4_err_drop", 64'(rsp_err), 64'd0);
    late_req++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_late_rv",   64'(rsp_valid), 64'd0);
      chk("t4_late_busy", 64'(busy),      64'd0);
    end
    chk("t4_late_cos", 64'(rsp_cos), 64'd0);
    men = 1'b1;

    // 5a: sin 2 cycles before cos -> one rsp at t+6
    lc = 4; ls = 2;
    cos_d = 300; sin_d = 400;
    req_theta[0 +: W] = 777;
    req_valid = 2'b01;
    pulses = 0;
    first = 0;
    pc = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (rsp_valid != '0) begin
        pulses++;
        if (pulses == 1) begin first = k; pc = rsp_cos; end
        req_valid = '0;
      end
    end
    chk("t5_pulses", 64'(pulses), 64'd1);
    chk("t5_cycle",  64'(first),  64'd6);
    chk("t5_cos",    64'(pc),     64'd300);

    // 5b: reset mid-WAIT, then rr_ptr must be back at 0
    lc = 5; ls = 5;
    req_theta[W +: W] = 2000;
    req_valid = 2'b10;
    tick(); tick(); tick();
    chk("t5_busy_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_rv",   64'(rsp_valid),   64'd0);
    chk("t5_rst_tv",   64'(theta_valid), 64'd0);
    chk("t5_rst_th",   64'(theta),       64'd0);
    chk("t5_rst_cos",  64'(rsp_cos),     64'd0);
    chk("t5_rst_busy", 64'(busy),        64'd0);
    req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_post_rv", 64'(rsp_valid), 64'd0);
    end
    lc = 1; ls = 1;
    req_theta[0 +: W] = 1000;
    req_valid = 2'b11;
    wait_tv("t5_rr_tv");
    chk("t5_rr_th", 64'(theta), 64'd1000);
    wait_rsp("t5_rr_wait");
    chk("t5_rr_rv", 64'(rsp_valid), 64'b01);
    req_valid = '0;
    tick(); tick();

    // 6: repeated theta
    lc = 2; ls = 2;
    txn("t6a", 0, 102943, 111, 222, 111, 222);
    req_theta[0 +: W] = 102943;
    cos_d = 5; sin_d = 6;
    req_valid = 2'b01;
    tick();
`ifdef CLBP_TRIG_CACHE_EN
    chk("t6_tv",  64'(theta_valid), 64'd0);
    chk("t6_rv",  64'(rsp_valid),   64'b01);
    chk("t6_cos", 64'(rsp_cos),     64'd111);
    chk("t6_sin", 64'(rsp_sin),     64'd222);
`else
    chk("t6_tv", 64'(theta_valid), 64'd1);
    wait_rsp("t6_wait");
    chk("t6_cos", 64'(rsp_cos), 64'd5);
`endif
    req_valid = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
